mem_lsu: RTL and testbench

Load/store unit that sits between the core's execute stage and the byte-addressed, 32-bit-port data memory. It is the initiator side of the memory `A/WD/WE/RD` interface. It accepts one byte, halfword or word access at a time from the core and aligns it to a word boundary. Sub-word stores are done as a read-modify-write, because the memory always writes four bytes. Loaded data is returned sign- or zero-extended.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_lane_align.sv | 45 ++++
 rtl/mem_lsu.sv | 118 +++++++++++
 tb/tb_mem_lsu.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    DONE = 2'b11
  } lsu_state_e;

  // True when the access cannot be served within one aligned word.
  function automatic logic is_misaligned(size_e sz, logic [1:0] ln);
    logic bad;
    case (sz)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = ln[0];
      SZ_WORD: bad = |ln;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane extract/extend for loads and lane merge for sub-word stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] rword,
  input  logic [1:0]  ln,
  input  size_e       size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [4:0]  sh;
  logic [31:0] shifted;
  logic [31:0] mask;

  assign sh      = {ln, 3'b000};
  assign shifted = rword >> sh;

  // Extract the addressed lane(s) and extend to 32 bits.
  always_comb begin
    load_data = rword;
    case (size)
      SZ_BYTE: load_data = is_unsigned ? {24'h0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_data = is_unsigned ? {16'h0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = rword;
    endcase
  end

  // Lanes covered by the store; words cover all four.
  always_comb begin
    mask = 32'hFFFF_FFFF;
    case (size)
      SZ_BYTE: mask = 32'h0000_00FF << sh;
      SZ_HALF: mask = 32'h0000_FFFF << sh;
      default: mask = 32'hFFFF_FFFF;
    endcase
  end

  assign merged_word = (rword & ~mask) | ((wdata << sh) & mask);

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: word-aligns core accesses, RMW for sub-word stores.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned AW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req,
  input  logic          i_we,
  input  logic [1:0]    i_size,
  input  logic          i_unsigned,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic          o_ready,
  output logic          o_done,
  output logic          o_err,
  output logic [31:0]   o_rdata,
  output logic [AW-1:0] o_A,
  output logic [31:0]   o_WD,
  output logic          o_WE,
  input  logic [31:0]   i_RD
);

  lsu_state_e    state_q, state_d;
  logic          we_q;
  size_e         size_q;
  logic          uns_q;
  logic [AW-1:0] wa_q;
  logic [1:0]    ln_q;
  logic [31:0]   wdata_q;
  logic          err_q;
  logic [31:0]   rword_q;

  logic          accept;
  logic          req_err;
  logic [31:0]   align_word;
  logic [31:0]   load_data;
  logic [31:0]   merged_word;

  assign accept  = (state_q == IDLE) && i_req;
  assign req_err = is_misaligned(size_e'(i_size), i_addr[1:0]);

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_req) begin
          if (req_err)                                 state_d = DONE;
          else if (!i_we)                              state_d = RD;
          else if (size_e'(i_size) == SZ_WORD)         state_d = WR;
          else                                         state_d = RD;
        end
      end
      RD:      state_d = we_q ? WR : DONE;
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, read-word capture and load result.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      wa_q    <= '0;
      ln_q    <= 2'b00;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
      rword_q <= 32'h0;
      o_rdata <= 32'h0;
    end else begin
      if (accept) begin
        we_q    <= i_we;
        size_q  <= size_e'(i_size);
        uns_q   <= i_unsigned;
        wa_q    <= {i_addr[AW-1:2], 2'b00};
        ln_q    <= i_addr[1:0];
        wdata_q <= i_wdata;
        err_q   <= req_err;
      end
      if (state_q == RD) begin
        rword_q <= i_RD;
        if (!we_q) o_rdata <= load_data;
      end
    end
  end

  // Loads extract straight from the bus in RD; stores merge from the captured word.
  assign align_word = (state_q == RD) ? i_RD : rword_q;

  lsu_lane_align u_align (
    .rword       (align_word),
    .ln          (ln_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  assign o_ready = (state_q == IDLE);
  assign o_done  = (state_q == DONE);
  assign o_err   = (state_q == DONE) && err_q;
  assign o_A     = ((state_q == RD) || (state_q == WR)) ? wa_q : '0;
  assign o_WE    = (state_q == WR);
  assign o_WD    = (state_q == WR) ? merged_word : 32'h0;

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu against a byte-array reference model.
module tb_mem_lsu;

  localparam int unsigned AW = 16;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_req = 1'b0;
  logic          i_we = 1'b0;
  logic [1:0]    i_size = 2'b00;
  logic          i_unsigned = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [31:0]   i_wdata = 32'h0;
  logic          o_ready, o_done, o_err, o_WE;
  logic [31:0]   o_rdata, o_WD, i_RD;
  logic [AW-1:0] o_A;

  mem_lsu #(.AW(AW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_we(i_we),
    .i_size(i_size), .i_unsigned(i_unsigned), .i_addr(i_addr),
    .i_wdata(i_wdata), .o_ready(o_ready), .o_done(o_done), .o_err(o_err),
    .o_rdata(o_rdata), .o_A(o_A), .o_WD(o_WD), .o_WE(o_WE), .i_RD(i_RD)
  );

  always #5 i_clk = ~i_clk;

  // Data memory the DUT drives.
  logic [31:0] mem [0:16383];
  assign i_RD = mem[o_A[15:2]];
  always @(posedge i_clk) if (o_WE) mem[o_A[15:2]] <= o_WD;

  // Reference: byte-addressed memory and last load result.
  logic [7:0]  rmem [0:65535];
  logic [31:0] last_rdata = 32'h0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          acc;
    logic        we_exp;
    logic [15:0] wa;
    logic [31:0] wd;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   we_cnt = 0;
  bit   mon_en = 1'b0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s actual=timeout required=event", nm);
  endtask

  function automatic logic ref_err(input logic [1:0] sz, input logic [15:0] a);
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1) return a[0];
    if (sz == 2'd2) return a[1:0] != 2'b00;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_word(input logic [15:0] wa);
    return {rmem[wa + 16'd3], rmem[wa + 16'd2], rmem[wa + 16'd1], rmem[wa]};
  endfunction

  // Monitor: pops an expectation on every o_done and checks bus behaviour.
  always @(negedge i_clk) begin
    if (mon_en) begin
      if (o_WE) begin
        we_cnt++;
        if (q.size() == 0) begin
          chk("we_without_access", 32'(o_WE), 32'h0);
        end else begin
          chk("we_addr", 32'(o_A), 32'(q[0].wa));
          chk("we_data", o_WD, q[0].wd);
        end
      end else begin
        chk("wd_idle", o_WD, 32'h0);
      end
      if (o_ready) chk("a_idle", 32'(o_A), 32'h0);
      if (o_done) begin
        if (q.size() == 0) begin
          chk("spurious_done", 32'(o_done), 32'h0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("err", 32'(o_err), 32'(e.err));
          chk("rdata", o_rdata, e.rdata);
          chk("latency", 32'(cyc - e.acc), 32'(e.lat));
          chk("we_count", 32'(we_cnt), e.we_exp ? 32'd1 : 32'd0);
        end
        we_cnt = 0;
      end
    end
  end

  // Drive one request once the unit is ready; the model computes the expectation.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [15:0] a, input logic [31:0] wd,
                       input bit hold, output int acc);
    exp_t e;
    int   n = 0;
    int   nb;
    logic [31:0] v;
    @(negedge i_clk);
    while (!o_ready && n < 50) begin @(negedge i_clk); n++; end
    if (n >= 50) timeout_fail("ready_wait");
    i_req = 1'b1; i_we = we; i_size = sz; i_unsigned = uns; i_addr = a; i_wdata = wd;
    @(posedge i_clk);
    #1;
    acc = cyc - 1;
    e.acc = acc; e.err = ref_err(sz, a); e.we_exp = 1'b0;
    e.wa = a & 16'hFFFC; e.wd = 32'h0;
    if (e.err) begin
      e.lat = 1;
    end else if (!we) begin
      nb = 1 << sz;
      v = 32'h0;
      for (int i = 0; i < nb; i++) v = v | (32'(rmem[16'(a + i)]) << (8 * i));
      if (!uns && sz == 2'd0) v = {{24{v[7]}}, v[7:0]};
      if (!uns && sz == 2'd1) v = {{16{v[15]}}, v[15:0]};
      last_rdata = v;
      e.lat = 2;
    end else begin
      nb = 1 << sz;
      for (int i = 0; i < nb; i++) rmem[16'(a + i)] = wd[8*i +: 8];
      e.lat = (sz == 2'd2) ? 2 : 3;
      e.we_exp = 1'b1;
      e.wd = ref_word(e.wa);
    end
    e.rdata = last_rdata;
    q.push_back(e);
    if (!hold) i_req = 1'b0;
  endtask

  task automatic acc1(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [15:0] a, input logic [31:0] wd);
    int acc;
    issue(we, sz, uns, a, wd, 1'b0, acc);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge i_clk);
    while ((q.size() != 0 || !o_ready) && n < 100) begin @(negedge i_clk); n++; end
    if (n >= 100) timeout_fail("idle_wait");
  endtask

  initial begin
    int acc, prev;
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    for (int i = 0; i < 65536; i++) rmem[i] = 8'h0;

    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("rst_ready", 32'(o_ready), 32'h1);
    chk("rst_done", 32'(o_done), 32'h0);
    chk("rst_err", 32'(o_err), 32'h0);
    chk("rst_rdata", o_rdata, 32'h0);
    chk("rst_a", 32'(o_A), 32'h0);
    chk("rst_wd", o_WD, 32'h0);
    chk("rst_we", 32'(o_WE), 32'h0);
    mon_en = 1'b1;

    acc1(1'b1, 2'd2, 1'b0, 16'h0010, 32'hDEADBEEF);
    acc1(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0);
    wait_idle();
    chk("word_load", o_rdata, 32'hDEADBEEF);

    acc1(1'b1, 2'd2, 1'b0, 16'h0020, 32'h11223344);
    acc1(1'b1, 2'd0, 1'b0, 16'h0022, 32'h000000AA);
    acc1(1'b0, 2'd2, 1'b0, 16'h0020, 32'h0);
    wait_idle();
    chk("byte_merge", o_rdata, 32'h11AA3344);
    acc1(1'b0, 2'd0, 1'b0, 16'h0022, 32'h0);
    wait_idle();
    chk("byte_signed", o_rdata, 32'hFFFFFFAA);
    acc1(1'b0, 2'd0, 1'b1, 16'h0022, 32'h0);
    wait_idle();
    chk("byte_unsigned", o_rdata, 32'h000000AA);

    acc1(1'b1, 2'd1, 1'b0, 16'h0032, 32'h00008001);
    acc1(1'b0, 2'd1, 1'b0, 16'h0032, 32'h0);
    wait_idle();
    chk("half_signed", o_rdata, 32'hFFFF8001);
    acc1(1'b0, 2'd2, 1'b0, 16'h0030, 32'h0);
    wait_idle();
    chk("half_word", o_rdata, 32'h80010000);

    acc1(1'b0, 2'd1, 1'b0, 16'h0041, 32'h0);
    acc1(1'b0, 2'd2, 1'b0, 16'h0042, 32'h0);
    acc1(1'b0, 2'd3, 1'b0, 16'h0040, 32'h0);
    acc1(1'b1, 2'd1, 1'b0, 16'h0041, 32'hFFFF1234);
    acc1(1'b1, 2'd2, 1'b0, 16'h0042, 32'h12345678);
    acc1(1'b1, 2'd3, 1'b0, 16'h0040, 32'hCAFEF00D);
    wait_idle();
    chk("err_rdata_held", o_rdata, 32'h80010000);
    chk("err_mem_untouched", mem[16'h0040 >> 2], 32'h0);

    // Abort a byte store in its RD cycle.
    @(negedge i_clk);
    i_req = 1'b1; i_we = 1'b1; i_size = 2'd0; i_unsigned = 1'b0;
    i_addr = 16'h0050; i_wdata = 32'h000000C3;
    @(posedge i_clk);
    #1 i_req = 1'b0;
    i_rst_n = 1'b0;
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    last_rdata = 32'h0;
    @(negedge i_clk);
    chk("abort_ready", 32'(o_ready), 32'h1);
    chk("abort_we", 32'(o_WE), 32'h0);
    chk("abort_rdata", o_rdata, 32'h0);
    repeat (3) @(negedge i_clk);
    chk("abort_we_cnt", 32'(we_cnt), 32'h0);
    chk("abort_mem", mem[16'h0050 >> 2], 32'h0);
    acc1(1'b0, 2'd2, 1'b0, 16'h0020, 32'h0);
    wait_idle();
    chk("after_abort_load", o_rdata, 32'h11AA3344);

    acc1(1'b1, 2'd0, 1'b0, 16'hFFFF, 32'h0000005A);
    acc1(1'b0, 2'd2, 1'b0, 16'hFFFC, 32'h0);
    wait_idle();
    chk("top_byte", o_rdata, 32'h5A000000);

    // Back-to-back loads with i_req held high throughout.
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      issue(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0, 1'b1, acc);
      if (k > 0) chk("b2b_spacing", 32'(acc - prev), 32'd3);
      prev = acc;
    end
    i_req = 1'b0;
    wait_idle();

    for (int k = 0; k < 250; k++) begin
      logic [15:0] a;
      a = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255))
                                      : 16'(16'hFF00 + $urandom_range(0, 255));
      acc1(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), a, $urandom);
    end
    wait_idle();

    for (int w = 0; w < 64; w++)
      chk("mem_low", mem[w], ref_word(16'(w * 4)));
    for (int w = 16320; w < 16384; w++)
      chk("mem_high", mem[w], ref_word(16'(w * 4)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule
